// File: rtl/crossbar_cmd_gen_seq_pkg.sv
// xbar_pkg: crossbar sizing, command bit indexing and conflict counter width shared by both crossbar sides.
package xbar_pkg;
    localparam int NUM_INPUT_DATA  = 8;
    localparam int NUM_OUTPUT_DATA = 8;
    localparam int DEST_WIDTH      = $clog2(NUM_OUTPUT_DATA);
    localparam int CONFLICT_CNT_W  = 16;

    typedef logic [CONFLICT_CNT_W-1:0] conflict_cnt_t;

    function automatic int cmd_idx(input int in_idx, input int out_idx);
        return in_idx * NUM_OUTPUT_DATA + out_idx;
    endfunction
endpackage

// File: rtl/crossbar_cmd_gen_seq_rr_arbiter.sv
// rr_arbiter_seq: N-way round-robin arbiter; pointer moves past the winner only when upd_i is high.
module rr_arbiter_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         upd_i,
    output logic [N-1:0] gnt_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d, win;
    logic          found;
    int            idx;

    always_comb begin
        gnt_o = '0;
        win   = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                win        = PW'(idx);
            end
        end
        ptr_d = (found && upd_i) ? ((win == PW'(N - 1)) ? '0 : win + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/crossbar_cmd_gen_seq.sv
// crossbar_cmd_gen_seq: turns per-input destination requests into a registered one-hot crossbar command.
// Optional CMD_GEN_CONFLICT_CNT_EN adds a saturating count of cycles with unaccepted requests.
module crossbar_cmd_gen_seq
    import xbar_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_en,
    input  logic [NUM_INPUT_DATA-1:0]              i_req_valid,
    input  logic [NUM_INPUT_DATA*DEST_WIDTH-1:0]   i_req_dest,
    output logic [NUM_INPUT_DATA-1:0]              o_req_ready,
    output logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] o_cmd,
    output logic                                   o_en,
    output logic [NUM_INPUT_DATA-1:0]              o_valid
`ifdef CMD_GEN_CONFLICT_CNT_EN
    ,
    output logic [CONFLICT_CNT_W-1:0]              o_conflict_cnt
`endif
);
    logic [NUM_OUTPUT_DATA-1:0][NUM_INPUT_DATA-1:0] req, gnt;
    logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0]      cmd_d, cmd_q;
    logic [NUM_INPUT_DATA-1:0]                      acc, valid_q;
    logic                                           go, en_q;

    assign go = i_en && !rst;

    always_comb begin
        req = '0;
        for (int k = 0; k < NUM_INPUT_DATA; k++)
            for (int j = 0; j < NUM_OUTPUT_DATA; j++)
                req[j][k] = i_req_valid[k] && (i_req_dest[k*DEST_WIDTH +: DEST_WIDTH] == DEST_WIDTH'(j));
    end

    // Pointers advance only on cycles where grants are actually issued.
    for (genvar j = 0; j < NUM_OUTPUT_DATA; j++) begin : g_arb
        rr_arbiter_seq #(.N(NUM_INPUT_DATA)) u_arb (
            .clk   (clk),
            .rst   (rst),
            .req_i (req[j]),
            .upd_i (go),
            .gnt_o (gnt[j])
        );
    end

    always_comb begin
        cmd_d = '0;
        acc   = '0;
        for (int k = 0; k < NUM_INPUT_DATA; k++)
            for (int j = 0; j < NUM_OUTPUT_DATA; j++)
                if (go && gnt[j][k]) begin
                    cmd_d[cmd_idx(k, j)] = 1'b1;
                    acc[k]               = 1'b1;
                end
    end

    assign o_req_ready = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q   <= '0;
            valid_q <= '0;
            en_q    <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            valid_q <= acc;
            en_q    <= i_en;
        end
    end

    assign o_cmd   = cmd_q;
    assign o_valid = valid_q;
    assign o_en    = en_q;

`ifdef CMD_GEN_CONFLICT_CNT_EN
    conflict_cnt_t cnt_q, cnt_d;

    assign cnt_d = (go && |(i_req_valid & ~acc) && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign o_conflict_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_crossbar_cmd_gen_seq.sv
// tb_crossbar_cmd_gen_seq: directed checks of grants, command timing, disable, reset and fairness.
module tb_crossbar_cmd_gen_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic [7:0]  i_req_valid;
    logic [23:0] i_req_dest;
    logic [7:0]  o_req_ready;
    logic [63:0] o_cmd;
    logic        o_en;
    logic [7:0]  o_valid;
`ifdef CMD_GEN_CONFLICT_CNT_EN
    logic [15:0] o_conflict_cnt;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    crossbar_cmd_gen_seq dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_req_valid (i_req_valid),
        .i_req_dest  (i_req_dest),
        .o_req_ready (o_req_ready),
        .o_cmd       (o_cmd),
        .o_en        (o_en),
        .o_valid     (o_valid)
`ifdef CMD_GEN_CONFLICT_CNT_EN
        ,
        .o_conflict_cnt (o_conflict_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic dest_all(input int d);
        for (int k = 0; k < 8; k++) i_req_dest[k*3 +: 3] = 3'(d);
    endtask

    logic [63:0] exp_cmd;

    initial begin
        rst = 1'b1; i_en = 1'b1; i_req_valid = 8'hFF; i_req_dest = '0;
        step();
        step();
        chk("rst_ready", 64'(o_req_ready), 64'h0);
        chk("rst_cmd", o_cmd, 64'h0);
        chk("rst_valid", 64'(o_valid), 64'h0);
        chk("rst_en", 64'(o_en), 64'h0);
        rst = 1'b0; i_req_valid = '0;
        #1 chk("idle_ready", 64'(o_req_ready), 64'h0);
        step();
        chk("idle_en", 64'(o_en), 64'h1);
        chk("idle_cmd", o_cmd, 64'h0);

        for (int k = 0; k < 8; k++) i_req_dest[k*3 +: 3] = 3'(7 - k);
        i_req_valid = 8'hFF;
        #1 chk("perm_ready", 64'(o_req_ready), 64'hFF);
        step();
        exp_cmd = '0;
        for (int k = 0; k < 8; k++) exp_cmd[k*8 + 7 - k] = 1'b1;
        chk("perm_cmd", o_cmd, exp_cmd);
        chk("perm_cmd_lit", o_cmd, 64'h0102040810204080);
        chk("perm_valid", 64'(o_valid), 64'hFF);

        // Contention on output 3 from inputs 2, 5, 7.
        do_reset();
        dest_all(3); i_req_valid = 8'hA4;
        #1 chk("c3_rdy1", 64'(o_req_ready), 64'h04);
        step();
        chk("c3_cmd1", o_cmd, 64'h1 << 19);
        chk("c3_val1", 64'(o_valid), 64'h04);
        i_req_valid = 8'hA0;
        #1 chk("c3_rdy2", 64'(o_req_ready), 64'h20);
        step();
        chk("c3_cmd2", o_cmd, 64'h1 << 43);
        i_req_valid = 8'h80;
        #1 chk("c3_rdy3", 64'(o_req_ready), 64'h80);
        step();
        chk("c3_cmd3", o_cmd, 64'h1 << 59);
`ifdef CMD_GEN_CONFLICT_CNT_EN
        chk("c3_cnt", 64'(o_conflict_cnt), 64'd2);
`endif
        i_req_valid = 8'h81;
        #1 chk("c3_ptr0", 64'(o_req_ready), 64'h01);
        step();
        chk("c3_ptr0_cmd", o_cmd, 64'h1 << 3);

        // Disable after first grant; pointer must hold.
        do_reset();
        dest_all(3); i_req_valid = 8'hA4;
        #1 chk("dis_rdy1", 64'(o_req_ready), 64'h04);
        step();
        chk("dis_cmd1", o_cmd, 64'h1 << 19);
        i_req_valid = 8'hA0; i_en = 1'b0;
        #1 chk("dis_rdy_off", 64'(o_req_ready), 64'h0);
        step();
        chk("dis_cmd_off", o_cmd, 64'h0);
        chk("dis_en_off", 64'(o_en), 64'h0);
        chk("dis_val_off", 64'(o_valid), 64'h0);
        step();
        chk("dis_cmd_off2", o_cmd, 64'h0);
        i_en = 1'b1;
        #1 chk("dis_rdy_resume", 64'(o_req_ready), 64'h20);
        step();
        chk("dis_cmd_resume", o_cmd, 64'h1 << 43);
        chk("dis_en_on", 64'(o_en), 64'h1);
        i_req_valid = 8'h80;
        #1 chk("dis_rdy_last", 64'(o_req_ready), 64'h80);
        step();
        chk("dis_cmd_last", o_cmd, 64'h1 << 59);

        // Reset while contention is in flight.
        do_reset();
        dest_all(3); i_req_valid = 8'hA4;
        step();
        chk("rc_cmd1", o_cmd, 64'h1 << 19);
        rst = 1'b1;
        #1 chk("rc_rdy_rst", 64'(o_req_ready), 64'h0);
        step();
        chk("rc_cmd_clr", o_cmd, 64'h0);
        chk("rc_val_clr", 64'(o_valid), 64'h0);
        rst = 1'b0;
        #1 chk("rc_rdy_again", 64'(o_req_ready), 64'h04);
        step();
        chk("rc_cmd_again", o_cmd, 64'h1 << 19);

        i_req_valid = '0;
        step();
        chk("end_idle_cmd", o_cmd, 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/crossbar_cmd_gen_seq.md
Name: crossbar_cmd_gen_seq

Overview:
- Produces the one-hot command matrix, enable and per-input acceptance that drive the pipelined one-hot crossbar.
- Sits upstream of the crossbar, on the sender side of the same command interface.
- Converts per-input binary destination requests into a registered NUM_INPUT_DATA x NUM_OUTPUT_DATA one-hot command.
- Resolves output contention with a per-output round-robin arbiter and back-pressures losing inputs until they are granted.

Parameters:
- NUM_INPUT_DATA, 8: number of crossbar inputs (requesters).
- NUM_OUTPUT_DATA, 8: number of crossbar outputs; power of 2.
- DEST_WIDTH, log2(NUM_OUTPUT_DATA) = 3: width of one destination index.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- i_en  input  1  generator enable; when low, no grants are issued.
- i_req_valid  input  NUM_INPUT_DATA  per-input request valid.
- i_req_dest  input  NUM_INPUT_DATA*DEST_WIDTH  per-input destination index; input k occupies bits [k*DEST_WIDTH +: DEST_WIDTH].
- o_req_ready  output  NUM_INPUT_DATA  combinational grant/accept for each input.
- o_cmd  output  NUM_INPUT_DATA*NUM_OUTPUT_DATA  registered one-hot command; bit [in*NUM_OUTPUT_DATA+out] routes input in to output out.
- o_en  output  1  registered crossbar enable.
- o_valid  output  NUM_INPUT_DATA  registered copy of the accepted inputs, aligned with o_cmd.

Behaviour:
- Reset (rst=1 at a clock edge):
  - o_cmd=0, o_en=0, o_valid=0.
  - All round-robin pointers = 0.
  - o_req_ready is forced to 0 while rst=1.
- Arbitration, combinational in cycle t:
  - For each output j, the candidate set is {k : i_req_valid[k] && i_req_dest[k]==j}.
  - The winner is the first candidate at or after ptr[j], searching upward with wrap-around modulo NUM_INPUT_DATA.
  - o_req_ready[k]=1 iff input k wins its output, i_en=1 and rst=0.
  - An input targets exactly one output, so each input wins at most once per cycle.
  - o_req_ready never depends on o_req_ready of other blocks, so there are no combinational loops.
- Handshake:
  - A request transfers when valid && ready.
  - A losing input must hold valid and dest stable until accepted.
  - The generator does not store requests.
  - ready may be asserted in the same cycle valid first rises.
- Registered outputs, at the edge ending cycle t:
  - o_cmd[k*NUM_OUTPUT_DATA+j] = 1 iff input k was accepted for output j.
  - o_valid[k] = accepted[k].
  - o_en = i_en.
  - Latency is exactly 1 cycle from acceptance to o_cmd.
- Column invariant: each output column of o_cmd has at most one bit set. Each row also has at most one bit set.
- Pointer update: on a grant at output j to input w, ptr[j] <= (w+1) mod NUM_INPUT_DATA. Without a grant, ptr[j] holds.
- i_en=0:
  - All ready=0.
  - Next-cycle o_cmd=0, o_valid=0, o_en=0.
  - Pointers hold.
- Idle (no valid requests): o_cmd=0 next cycle, o_en follows i_en, pointers hold.
- Reset mid-operation: any in-flight o_cmd is cleared on the reset edge. Requests pending at reset must be re-presented, and no grant is issued while rst=1.
- Fairness: with N persistent contenders on one output, each is granted exactly once in every N consecutive grants.

Optional Feature:
- Macro: CMD_GEN_CONFLICT_CNT_EN.
- Defined:
  - Adds output port o_conflict_cnt, 16 bits.
  - Increments by 1 each cycle with i_en=1 in which at least one valid request is not accepted.
  - Saturates at 16'hFFFF.
  - Resets to 0.
- Undefined: the port and the counter logic are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package xbar_pkg:
  - NUM_INPUT_DATA/NUM_OUTPUT_DATA defaults and DEST_WIDTH.
  - Command index function cmd_idx(in,out) = in*NUM_OUTPUT_DATA+out, shared with the crossbar side.
  - Counter width constant CONFLICT_CNT_W=16.
- Sub-module rr_arbiter_seq: N-way round-robin with a registered pointer, a request vector in and a one-hot grant out, with an update strobe. Instantiated once per output.

Test Plan:
1. Reset and idle:
   - Stimulus: rst=1 for 2 cycles, then i_en=1 with no valid requests.
   - Required: o_cmd=0, o_valid=0, o_req_ready=0, o_en=0 during reset; o_en=1 one cycle after release.
2. Permutation, no conflict:
   - Stimulus: inputs 0..7 valid with dest = 7-k.
   - Required: all ready=1 the same cycle; next cycle o_cmd bits {7, 14, 21, 28, 35, 42, 49, 56} set, o_valid=8'hFF.
3. Contention fairness:
   - Stimulus: inputs 2, 5 and 7 all target output 3, held until accepted.
   - Required: grant order 2, 5, 7 over three cycles. ptr[3] ends at 0. The o_cmd bits set across the three cycles are 19, 43, 59.
4. Disable mid-stream:
   - Stimulus: repeat case 3 and drop i_en after the first grant for 2 cycles.
   - Required: ready=0 and o_cmd=0 in the cycles following, and ptr holds. On re-enable the order resumes with 5, then 7.
5. Reset during contention:
   - Stimulus: assert rst after input 2 is granted in case 3.
   - Required: o_cmd cleared on the next edge and ptr reset to 0. After release, input 2 is granted first again if it is still requesting.
6. Conflict counter (CMD_GEN_CONFLICT_CNT_EN defined):
   - Stimulus: case 3.
   - Required: the counter reads 2 after three accepts (cycles 1 and 2 each had losers; cycle 3 had none). Forcing it to 16'hFFFE and continuing contention saturates it at 16'hFFFF.
